// File: rtl/reg_file_if.sv
// reg_file_if -- operand-read / issue / commit bundle for the register file.
//   slave  : register-file side (reads issue, commit, clear and RoB query
//            results; drives operand values, busy flags, tags and RoB queries)
//   master : core side (issue stage + reorder buffer)
// Signals:
//   issue_ready/issue_rd/issue_robid   rename a destination to an RoB tag
//   rs1/rs2                            source indices of the issuing instruction
//   rs*_val/rs*_busy/rs*_tag           resolved operands
//   get_RoBid_*, RoB_busy_*, RoB_value_* reorder-buffer lookup of pending tags
//   commit_valid/rd/robid/value        retirement write port
//   clear                              mispredict flush
interface reg_file_if #(parameter int ROB_BITS = 4);
   logic                issue_ready;
   logic [4:0]          issue_rd;
   logic [ROB_BITS-1:0] issue_robid;
   logic [4:0]          rs1;
   logic [4:0]          rs2;
   logic [31:0]         rs1_val;
   logic [31:0]         rs2_val;
   logic                rs1_busy;
   logic                rs2_busy;
   logic [ROB_BITS-1:0] rs1_tag;
   logic [ROB_BITS-1:0] rs2_tag;
   logic [ROB_BITS-1:0] get_RoBid_1;
   logic [ROB_BITS-1:0] get_RoBid_2;
   logic                RoB_busy_1;
   logic                RoB_busy_2;
   logic [31:0]         RoB_value_1;
   logic [31:0]         RoB_value_2;
   logic                commit_valid;
   logic [4:0]          commit_rd;
   logic [ROB_BITS-1:0] commit_robid;
   logic [31:0]         commit_value;
   logic                clear;

   modport slave (
      input  issue_ready, issue_rd, issue_robid, rs1, rs2,
      input  RoB_busy_1, RoB_busy_2, RoB_value_1, RoB_value_2,
      input  commit_valid, commit_rd, commit_robid, commit_value, clear,
      output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
      output get_RoBid_1, get_RoBid_2
   );

   modport master (
      output issue_ready, issue_rd, issue_robid, rs1, rs2,
      output RoB_busy_1, RoB_busy_2, RoB_value_1, RoB_value_2,
      output commit_valid, commit_rd, commit_robid, commit_value, clear,
      input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag,
      input  get_RoBid_1, get_RoBid_2
   );
endinterface

// File: rtl/reg_file.sv
// reg_file -- 32 x 32-bit architectural register file with rename tags.
// Each register carries a busy bit and the RoB tag of its pending producer.
// Operand reads are combinational and see state from before this cycle's
// issue, resolving through stored value, optional same-cycle commit bypass,
// or the reorder-buffer query result.
// Ports:
//   clk_in   system clock
//   rst_in   synchronous active-high reset (wins over rdy_in)
//   rdy_in   low = hold all state
//   bus      reg_file_if.slave bundle (issue, reads, RoB query, commit, clear)
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle commit
// into operand reads.
module reg_file #(
   parameter int ROB_BITS = 4
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   reg_file_if.slave   bus
);

   typedef struct packed {
      logic                busy;
      logic [ROB_BITS-1:0] tag;
      logic [31:0]         val;
   } rd_t;

   logic [31:0]         vals [32];
   logic [31:0]         busy;
   logic [ROB_BITS-1:0] tags [32];

   // Commit is applied before issue so a same-cycle issue to the same rd
   // leaves busy set with the new tag while the value is still written.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         for (int unsigned i = 0; i < 32; i++) begin
            vals[i] <= '0;
            tags[i] <= '0;
         end
         busy <= '0;
      end else if (rdy_in) begin
         if (bus.commit_valid && bus.commit_rd != 5'd0) begin
            vals[bus.commit_rd] <= bus.commit_value;
            if (tags[bus.commit_rd] == bus.commit_robid)
               busy[bus.commit_rd] <= 1'b0;
         end
         if (bus.clear) begin
            busy <= '0;
         end else if (bus.issue_ready && bus.issue_rd != 5'd0) begin
            busy[bus.issue_rd] <= 1'b1;
            tags[bus.issue_rd] <= bus.issue_robid;
         end
      end
   end

   function automatic rd_t resolve(
      input logic [4:0]          rs,
      input logic [31:0]         sval,
      input logic                sbusy,
      input logic [ROB_BITS-1:0] stag,
      input logic                hit,
      input logic [31:0]         hval,
      input logic                rob_busy,
      input logic [31:0]         rob_val
   );
      rd_t r;
      r.busy = 1'b0;
      r.tag  = stag;
      r.val  = '0;
      if (rs == 5'd0)      r.val  = '0;
      else if (!sbusy)     r.val  = sval;
      else if (hit)        r.val  = hval;
      else if (!rob_busy)  r.val  = rob_val;
      else                 r.busy = 1'b1;
      return r;
   endfunction

   logic hit1, hit2;
   rd_t  r1, r2;

`ifdef REGFILE_BYPASS_EN
   assign hit1 = bus.commit_valid && bus.commit_rd == bus.rs1 &&
                 bus.commit_robid == tags[bus.rs1];
   assign hit2 = bus.commit_valid && bus.commit_rd == bus.rs2 &&
                 bus.commit_robid == tags[bus.rs2];
`else
   assign hit1 = 1'b0;
   assign hit2 = 1'b0;
`endif

   always_comb begin
      r1 = resolve(bus.rs1, vals[bus.rs1], busy[bus.rs1], tags[bus.rs1],
                   hit1, bus.commit_value, bus.RoB_busy_1, bus.RoB_value_1);
      r2 = resolve(bus.rs2, vals[bus.rs2], busy[bus.rs2], tags[bus.rs2],
                   hit2, bus.commit_value, bus.RoB_busy_2, bus.RoB_value_2);
   end

   assign bus.rs1_val     = r1.val;
   assign bus.rs1_busy    = r1.busy;
   assign bus.rs1_tag     = r1.tag;
   assign bus.rs2_val     = r2.val;
   assign bus.rs2_busy    = r2.busy;
   assign bus.rs2_tag     = r2.tag;
   assign bus.get_RoBid_1 = tags[bus.rs1];
   assign bus.get_RoBid_2 = tags[bus.rs2];

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have parameter ROB_BITS, default 4, the width of reorder-buffer entry tags (16 entries).
REQ-002 SHALL have ports, clock and reset first:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  low = pause, no state change
- issue_ready  in  1  an instruction is issued this cycle
- issue_rd  in  5  destination register of the issued instruction
- issue_robid  in  ROB_BITS  reorder-buffer tag of the issued instruction (RoB tail)
- rs1, rs2  in  5  source register indices of the issuing instruction
- rs1_val, rs2_val  out  32  operand value, valid when the busy flag is low
- rs1_busy, rs2_busy  out  1  operand still pending
- rs1_tag, rs2_tag  out  ROB_BITS  producing reorder-buffer tag when busy
- get_RoBid_1, get_RoBid_2  out  ROB_BITS  tag query to the reorder buffer, equal to the stored tag of rs1/rs2
- RoB_busy_1, RoB_busy_2  in  1  queried reorder-buffer entry not yet complete
- RoB_value_1, RoB_value_2  in  32  queried reorder-buffer entry result
- commit_valid  in  1  the reorder buffer retires a register-writing instruction
- commit_rd  in  5  retiring destination register
- commit_robid  in  ROB_BITS  retiring tag
- commit_value  in  32  retiring result
- clear  in  1  flush on mispredict

Function
REQ-003 SHALL hold 32 x 32-bit values plus a per-register busy bit and ROB_BITS tag; x0 reads 0 with busy low and is never written or marked busy.
REQ-004 SHALL perform all state updates on posedge clk_in only when rdy_in is high; all reads are combinational.
REQ-005 Issue: issue_ready and issue_rd != 0 SHALL set busy[issue_rd]=1 and tag[issue_rd]=issue_robid next cycle.
REQ-006 Commit: commit_valid and commit_rd != 0 SHALL write value[commit_rd]=commit_value and clear busy[commit_rd] only if tag[commit_rd]==commit_robid.
REQ-007 Simultaneous issue and commit to the same rd: the value SHALL be written, and busy/tag SHALL take the issue's settings (busy=1, new tag).
REQ-008 clear SHALL zero every busy bit next cycle and SHALL ignore a same-cycle issue; a same-cycle commit value write SHALL still occur.
REQ-009 Read priority per source: rs==0 -> 0, not busy; busy low -> stored value; REGFILE_BYPASS_EN commit match (commit_valid, rd equal, tag equal) -> commit_value, not busy; RoB_busy_x low -> RoB_value_x, not busy; else busy=1, tag=stored tag.
REQ-010 Reads SHALL reflect state before this cycle's issue, so an instruction never depends on itself (e.g. add x1,x1,x1).
REQ-011 Tags SHALL compare as raw ROB_BITS values; wrap-around is owned by the reorder buffer.

Reset
REQ-012 rst_in high at posedge SHALL zero all values, busy bits and tags regardless of rdy_in, overriding issue, commit and clear; outputs then read 0 and not busy.
REQ-013 Reset asserted mid-operation SHALL discard all pending tags without exception.

Configuration
REQ-014 Macro REGFILE_BYPASS_EN defined: same-cycle commit forwards to reads per REQ-009. Not defined: that step is absent and resolution comes from the stored state or the reorder-buffer query only; REQ-003 to REQ-008 and REQ-010 to REQ-013 are unchanged.

Verification
REQ-015 Issue rd=5, robid=3; next cycle rs1=5, RoB_busy_1=1 -> rs1_busy=1, rs1_tag=3, get_RoBid_1=3.
REQ-016 Then commit rd=5, robid=3, value=0x1234 -> next cycle rs1_val=0x1234, busy=0; with the bypass enabled, same-cycle rs1_val=0x1234, busy=0.
REQ-017 Issue rd=7 with tag 2, then issue rd=7 with tag 9, then commit rd=7 tag 2 value 0xAA -> value[7]=0xAA, busy stays 1, tag 9.
REQ-018 Tags pending on x1 and x2, then clear together with issue rd=4 -> next cycle all busy=0 and x4 not busy.
REQ-019 Issue rd=0, commit rd=0 value 0xFFFF -> rs1=0 reads 0, not busy; rdy_in=0 during an issue -> no change.
